// File: rtl/cpu_pkg.sv
// Shared types and constants for the CPU front end: fetch FSM states,
// the NOP encoding, the default reset PC and the word-alignment helper.
package cpu_pkg;

    localparam int          WORD_W           = 32;
    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_STALLED = 2'd2
    } fetch_state_e;

    function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage
// (master) and the instruction memory (slave).
interface if_fetch_stage_if;
    import cpu_pkg::*;

    logic              req;
    logic [WORD_W-1:0] addr;
    logic              ready;
    logic [WORD_W-1:0] rdata;

    modport master (output req, output addr, input ready, input rdata);
    modport slave  (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a
// bubble is inserted.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              hold,
    input  logic              load,
    input  logic [WORD_W-1:0] instr_in,
    input  logic [WORD_W-1:0] pc4_in,
    output logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              valid
);

    // Pipeline register update with flush/hold/load priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instruction <= NOP;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (flush) begin
            instruction <= NOP;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end else if (hold) begin
            instruction <= instruction;
            pc_plus4    <= pc_plus4;
            valid       <= valid;
        end else if (load) begin
            instruction <= instr_in;
            pc_plus4    <= pc4_in;
            valid       <= 1'b1;
        end else begin
            instruction <= NOP;
            pc_plus4    <= 32'h0000_0000;
            valid       <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM with a one-entry skid
// buffer for stalls, redirect/kill tracking and the IF/ID register.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_write,
    input  logic                if_id_flush,
    input  logic                redirect_valid,
    input  logic [WORD_W-1:0]   redirect_target,
    if_fetch_stage_if.master    imem,
    output logic [WORD_W-1:0]   pc_out,
    output logic [WORD_W-1:0]   if_id_instruction,
    output logic [WORD_W-1:0]   if_id_pc_plus4,
    output logic                if_id_valid
);

    fetch_state_e      state_r;
    logic [WORD_W-1:0] pc_r;
    logic              req_r;
    logic              kill_r;
    logic [WORD_W-1:0] pending_pc_r;
    logic              skid_valid_r;
    logic [WORD_W-1:0] skid_instr_r;
    logic [WORD_W-1:0] skid_pc4_r;

    logic              accept_s;
    logic [WORD_W-1:0] target_s;
    logic [WORD_W-1:0] pc_plus4_s;
    logic              load_s;
    logic [WORD_W-1:0] load_instr_s;
    logic [WORD_W-1:0] load_pc4_s;

    assign accept_s   = req_r & imem.ready;
    assign target_s   = word_align(redirect_target);
    assign pc_plus4_s = pc_r + 32'd4;
    assign imem.req   = req_r;
    assign imem.addr  = pc_r;
    assign pc_out     = pc_r;

    // Pick the instruction offered to IF/ID; a redirect kills anything on the wrong path.
    always_comb begin
        load_s       = 1'b0;
        load_instr_s = NOP;
        load_pc4_s   = 32'h0000_0000;
        if (redirect_valid) begin
            load_s = 1'b0;
        end else if (skid_valid_r) begin
            load_s       = 1'b1;
            load_instr_s = skid_instr_r;
            load_pc4_s   = skid_pc4_r;
        end else if (accept_s && !kill_r) begin
            load_s       = 1'b1;
            load_instr_s = imem.rdata;
            load_pc4_s   = pc_plus4_s;
        end else begin
            load_s = 1'b0;
        end
    end

    // Fetch FSM, PC, pending-redirect and skid-buffer state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            req_r        <= 1'b0;
            kill_r       <= 1'b0;
            pending_pc_r <= 32'h0000_0000;
            skid_valid_r <= 1'b0;
            skid_instr_r <= NOP;
            skid_pc4_r   <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    state_r <= ST_FETCH;
                    req_r   <= 1'b1;
                    if (redirect_valid) begin
                        pc_r <= target_s;
                    end else begin
                        pc_r <= pc_r;
                    end
                end
                ST_FETCH: begin
                    if (accept_s) begin
                        kill_r <= 1'b0;
                        if (redirect_valid) begin
                            pc_r <= target_s;
                        end else if (kill_r) begin
                            pc_r <= pending_pc_r;
                        end else begin
                            pc_r <= pc_plus4_s;
                            // Decode is stalled: park the word so the request can drop.
                            if (!pc_write && !if_id_flush) begin
                                skid_valid_r <= 1'b1;
                                skid_instr_r <= imem.rdata;
                                skid_pc4_r   <= pc_plus4_s;
                                state_r      <= ST_STALLED;
                                req_r        <= 1'b0;
                            end else begin
                                state_r <= ST_FETCH;
                            end
                        end
                    end else if (redirect_valid) begin
                        pending_pc_r <= target_s;
                        kill_r       <= 1'b1;
                    end else begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_STALLED: begin
                    if (redirect_valid) begin
                        pc_r         <= target_s;
                        skid_valid_r <= 1'b0;
                        state_r      <= ST_FETCH;
                        req_r        <= 1'b1;
                    end else if (pc_write) begin
                        skid_valid_r <= 1'b0;
                        state_r      <= ST_FETCH;
                        req_r        <= 1'b1;
                    end else begin
                        state_r <= ST_STALLED;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .flush       (if_id_flush),
        .hold        (~pc_write),
        .load        (load_s),
        .instr_in    (load_instr_s),
        .pc4_in      (load_pc4_s),
        .instruction (if_id_instruction),
        .pc_plus4    (if_id_pc_plus4),
        .valid       (if_id_valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: memory returns 0x100+addr, and a
// scoreboard of expected {instruction, pc_plus4} pairs is popped per new IF/ID word.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst;
    logic        pc_write;
    logic        if_id_flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        ready;

    logic [31:0] pc_out,  if_id_instruction,  if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] pc_out2, if_id_instruction2, if_id_pc_plus42;
    logic        if_id_valid2;

    int          errors;
    int          checks;
    logic [63:0] sb_q[$];

    if_fetch_stage_if bus1();
    if_fetch_stage_if bus2();

    assign bus1.ready = ready;
    assign bus1.rdata = bus1.addr + 32'h0000_0100;
    assign bus2.ready = ready;
    assign bus2.rdata = bus2.addr + 32'h0000_0100;

    if_fetch_stage dut (
        .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_flush(if_id_flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem(bus1.master), .pc_out(pc_out), .if_id_instruction(if_id_instruction),
        .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .pc_write(pc_write), .if_id_flush(if_id_flush),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem(bus2.master), .pc_out(pc_out2), .if_id_instruction(if_id_instruction2),
        .if_id_pc_plus4(if_id_pc_plus42), .if_id_valid(if_id_valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock; if IF/ID was allowed to advance and now holds a word, it must be the next expected one.
    task automatic tick();
        logic        adv;
        logic [63:0] e;
        adv = pc_write;
        @(posedge clk);
        #1;
        if (adv && if_id_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got instr=%h pc4=%h, required no new instruction",
                         if_id_instruction, if_id_pc_plus4);
            end else begin
                e = sb_q.pop_front();
                if ({if_id_instruction, if_id_pc_plus4} !== e) begin
                    errors++;
                    $display("FAIL sb_order: got instr=%h pc4=%h, required instr=%h pc4=%h",
                             if_id_instruction, if_id_pc_plus4, e[63:32], e[31:0]);
                end
            end
        end
    endtask

    task automatic push_exp(input logic [31:0] addr);
        sb_q.push_back({addr + 32'h0000_0100, addr + 32'd4});
    endtask

    task automatic do_reset();
        rst             = 1'b0;
        pc_write        = 1'b1;
        if_id_flush     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0000_0000;
        ready           = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_sb_empty(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_sb_drain: got %0d pending, required 0", name, sb_q.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, bus1.req} !== 98'h0) begin
            errors++;
            $display("FAIL reset_values: got pc=%h instr=%h pc4=%h valid=%b req=%b, required all 0",
                     pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, bus1.req);
        end
        checks++;
        if (pc_out2 !== 32'hFFFF_FFFC || bus2.req !== 1'b0) begin
            errors++;
            $display("FAIL reset_pc_param: got pc=%h req=%b, required pc=fffffffc req=0", pc_out2, bus2.req);
        end
        rst   = 1'b1;
        ready = 1'b1;
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        tick();
        checks++;
        if (bus1.req !== 1'b1 || bus1.addr !== 32'h0 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL boot_edge1: got req=%b addr=%h valid=%b, required req=1 addr=0 valid=0",
                     bus1.req, bus1.addr, if_id_valid);
        end
        tick();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_instruction !== 32'h100) begin
            errors++;
            $display("FAIL first_latency: got valid=%b instr=%h, required valid=1 instr=00000100",
                     if_id_valid, if_id_instruction);
        end
        tick(); tick();
        test_sb_empty("reset_stream");
    endtask

    task automatic test_stall();
        pc_write = 1'b0;
        tick();
        checks++;
        if (bus1.req !== 1'b0 || if_id_instruction !== 32'h108 || if_id_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_enter: got req=%b instr=%h valid=%b, required req=0 instr=00000108 valid=1",
                     bus1.req, if_id_instruction, if_id_valid);
        end
        tick(); tick();
        checks++;
        if (pc_out !== 32'h10 || if_id_instruction !== 32'h108 || if_id_pc_plus4 !== 32'hC || bus1.req !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: got pc=%h instr=%h pc4=%h req=%b, required pc=00000010 instr=00000108 pc4=0000000c req=0",
                     pc_out, if_id_instruction, if_id_pc_plus4, bus1.req);
        end
        pc_write = 1'b1;
        push_exp(32'hC); push_exp(32'h10); push_exp(32'h14);
        tick(); tick(); tick();
        test_sb_empty("stall");
    endtask

    task automatic test_redirect_flush();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        if_id_flush     = 1'b1;
        tick();
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || pc_out !== 32'h40) begin
            errors++;
            $display("FAIL redirect_bubble: got valid=%b instr=%h pc=%h, required valid=0 instr=0 pc=00000040",
                     if_id_valid, if_id_instruction, pc_out);
        end
        redirect_valid = 1'b0;
        if_id_flush    = 1'b0;
        push_exp(32'h40);
        tick();
        test_sb_empty("redirect");
    endtask

    task automatic test_delayed_ready();
        ready           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0083;
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus1.req !== 1'b1 || bus1.addr !== 32'h44) begin
                errors++;
                $display("FAIL wait_stable_%0d: got req=%b addr=%h, required req=1 addr=00000044",
                         i, bus1.req, bus1.addr);
            end
            if (i < 2) tick();
        end
        ready = 1'b1;
        tick();
        checks++;
        if (bus1.addr !== 32'h80 || if_id_valid !== 1'b0) begin
            errors++;
            $display("FAIL kill_discard: got addr=%h valid=%b, required addr=00000080 valid=0",
                     bus1.addr, if_id_valid);
        end
        push_exp(32'h80);
        tick();
        test_sb_empty("delayed");
    endtask

    task automatic test_wrap();
        do_reset();
        rst   = 1'b1;
        ready = 1'b1;
        push_exp(32'h0);
        tick(); tick();
        checks++;
        if (if_id_valid2 !== 1'b1 || if_id_pc_plus42 !== 32'h0 || if_id_instruction2 !== 32'hFC || bus2.addr !== 32'h0 || pc_out2 !== 32'h0) begin
            errors++;
            $display("FAIL pc_wrap: got valid=%b pc4=%h instr=%h addr=%h, required valid=1 pc4=0 instr=000000fc addr=0",
                     if_id_valid2, if_id_pc_plus42, if_id_instruction2, bus2.addr);
        end
        test_sb_empty("wrap");
    endtask

    task automatic test_async_reset();
        push_exp(32'h4); push_exp(32'h8);
        tick(); tick();
        ready = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, bus1.req} !== 98'h0) begin
            errors++;
            $display("FAIL async_reset: got pc=%h instr=%h pc4=%h valid=%b req=%b, required all 0",
                     pc_out, if_id_instruction, if_id_pc_plus4, if_id_valid, bus1.req);
        end
        checks++;
        if (pc_out2 !== 32'hFFFF_FFFC || bus2.req !== 1'b0 || if_id_valid2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_wrap: got pc=%h req=%b valid=%b, required pc=fffffffc req=0 valid=0",
                     pc_out2, bus2.req, if_id_valid2);
        end
        test_sb_empty("async");
    endtask

    initial begin
        rst    = 1'b0;
        errors = 0;
        checks = 0;
        test_reset();
        test_stall();
        test_redirect_flush();
        test_delayed_ready();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch front end of the pipelined 32-bit CPU: owns the PC register, next-PC selection and the IF/ID pipeline register.
- Talks to instruction memory over a req/ready handshake; the memory may take several cycles to answer.
- Feeds the decode stage directly. Obeys stall (pc_write) from the hazard unit, and flush/redirect from branch/jump/jr resolution.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- pc_write  input  1  1 = pipeline may advance; 0 = hold PC and IF/ID (hazard stall).
- if_id_flush  input  1  force a bubble into IF/ID at the next edge.
- redirect_valid  input  1  taken branch/jump/jr this cycle.
- redirect_target  input  32  new PC when redirect_valid=1.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, word aligned.
- imem_ready  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction.
- pc_out  output  32  current PC (address of next/outstanding fetch).
- if_id_instruction  output  32  instruction to decode.
- if_id_pc_plus4  output  32  PC+4 of that instruction.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst=0, async): pc_out=RESET_PC; if_id_instruction=0 (NOP); if_id_pc_plus4=0; if_id_valid=0; imem_req=0; skid buffer empty; kill=0; state=BOOT.
- States: BOOT, FETCH, STALLED.
  - BOOT: imem_req=0. Next edge goes to FETCH.
  - FETCH: imem_req=1, imem_addr=pc_out.
    - req/addr stay stable until an edge where imem_ready=1 (accept).
    - Every accept sets pc_out <= pc_out+4 unless a redirect applies.
  - STALLED: imem_req=0. A fetched instruction waits in the 1-entry skid buffer.
    - Leave to FETCH when pc_write=1 (buffer drains to IF/ID) or on redirect (buffer discarded).
- Accept with pc_write=0 and no flush/redirect: store {rdata, pc+4} in the skid buffer and go to STALLED.
- Accept with pc_write=1: rdata goes straight to IF/ID. Stay in FETCH, so back-to-back requests give 1 instruction/cycle when ready is held high.
- Redirect handling:
  - No request outstanding (BOOT/STALLED), or accept on the same edge: pc_out <= redirect_target; in-flight data and buffer are discarded.
  - FETCH without ready: latch target into pending_pc and set kill. At the accept, discard the data, set pc_out <= pending_pc, clear kill.
  - A later redirect while kill=1 overwrites pending_pc.
  - Redirect beats pc_write=0 for PC update.
- IF/ID update priority, each edge:
  1. if_id_flush → instruction=0, pc_plus4=0, valid=0.
  2. pc_write=0 → hold.
  3. Instruction available (buffer full, or accept with kill=0 and no redirect) → load it, valid=1.
  4. Otherwise → bubble (valid=0, instruction=0).
- Arithmetic: pc+4 is modulo 2^32; 0xFFFF_FFFC wraps to 0. redirect_target bits [1:0] are forced to 0.
- Latency: with ready tied high, the first instruction is in IF/ID after the 2nd rising edge following reset release.
- Reset mid-request: imem_req drops immediately; the memory must tolerate an abandoned request.

Decomposition:
- Shared package cpu_pkg: fetch state enum, NOP constant (32'h0), default reset PC, word width 32.
- One sub-module: if_id_reg. It holds the IF/ID register with flush/hold/load priority and async active-low reset.
- The FSM, PC and skid buffer stay in the top module.

Test Plan:
- Reset release, ready=1, mem[a]=0x100+a → after edge 2: if_id_instruction=0x100, pc_plus4=4, valid=1. Then 0x104, 0x108 on consecutive edges.
- pc_write=0 for 3 cycles mid-stream → pc_out and IF/ID hold, imem_req drops once the buffer fills. After release the next instructions follow in order, none lost or duplicated.
- Redirect to 0x40 with ready=1 plus if_id_flush → one bubble (valid=0, instr=0), then if_id_instruction=mem[0x40], pc_plus4=0x44.
- Ready delayed 3 cycles; redirect to 0x80 in wait cycle 1 → addr stays stable until accept, data discarded, next request addr=0x80.
- RESET_PC=0xFFFF_FFFC → first IF/ID pc_plus4=0, next imem_addr=0.
- rst asserted between clock edges during a pending fetch → all outputs take reset values immediately, with no clock edge needed.
